mvu_fold_ctrl: RTL

//  Control unit for the matrix-vector unit (MVU) PE array. Folds a MATRIXH x MATRIXW weight matrix

---
 rtl/mvu_fold_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mvu_fold_ctrl.sv
// Sequencing controller for the folded MVU PE array: stream/buffer operand selection,
// weight addressing, accumulator tagging, stall propagation and result-valid pipe.
module mvu_fold_ctrl #(
  parameter  int SIMD    = 2,
  parameter  int PE      = 2,
  parameter  int MATRIXW = 4,
  parameter  int MATRIXH = 4,
  parameter  int PE_LAT  = 2,
  localparam int SF      = MATRIXW / SIMD,
  localparam int NF      = MATRIXH / PE,
  localparam int AW_IB   = (SF > 1) ? $clog2(SF) : 1,
  localparam int AW_WM   = (SF * NF > 1) ? $clog2(SF * NF) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_v,
  output logic             in_rdy,
  output logic             ib_wen,
  output logic [AW_IB-1:0] ib_waddr,
  output logic [AW_IB-1:0] ib_raddr,
  output logic             op_src,
  output logic [AW_WM-1:0] wmem_addr,
  output logic             op_v,
  output logic             acc_clr,
  output logic             acc_last,
  output logic             pe_en,
  output logic             out_v,
  input  logic             out_rdy
);

  localparam int AW_NF = (NF > 1) ? $clog2(NF) : 1;

  localparam logic [AW_IB-1:0] SF_LAST    = AW_IB'(SF - 1);
  localparam logic [AW_NF-1:0] NF_LAST    = AW_NF'(NF - 1);
  localparam logic [AW_WM-1:0] WADDR_LAST = AW_WM'(SF * NF - 1);

  if (MATRIXW % SIMD != 0) begin : g_chk_simd
    $error("mvu_fold_ctrl: MATRIXW must be a multiple of SIMD");
  end
  if (MATRIXH % PE != 0) begin : g_chk_pe
    $error("mvu_fold_ctrl: MATRIXH must be a multiple of PE");
  end
  if (PE_LAT < 1) begin : g_chk_lat
    $error("mvu_fold_ctrl: PE_LAT must be at least 1");
  end

  typedef enum logic {
    S_WRITE = 1'b0,
    S_READ  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW_IB-1:0]  sf_q, sf_d;
  logic [AW_NF-1:0]  nf_q, nf_d;
  logic [AW_WM-1:0]  waddr_q, waddr_d;
  logic [PE_LAT-1:0] tag_q, tag_d;

  logic issue;
  logic sf_wrap;

  always_comb begin
    out_v = tag_q[PE_LAT-1];
    pe_en = !(out_v && !out_rdy);
    in_rdy = pe_en && (state_q == S_WRITE);

    // Issue is suppressed while reset is asserted even if the stream presents a beat.
    issue = rst_n && pe_en && ((state_q == S_READ) || in_v);
    sf_wrap = (sf_q == SF_LAST);

    op_v      = issue;
    ib_wen    = issue && (state_q == S_WRITE);
    ib_waddr  = sf_q;
    ib_raddr  = sf_q;
    op_src    = (state_q == S_READ);
    wmem_addr = waddr_q;
    acc_clr   = issue && (sf_q == '0);
    acc_last  = issue && sf_wrap;

    state_d = state_q;
    sf_d    = sf_q;
    nf_d    = nf_q;
    waddr_d = waddr_q;

    if (issue) begin
      waddr_d = (waddr_q == WADDR_LAST) ? '0 : waddr_q + 1'b1;
      sf_d    = sf_wrap ? '0 : sf_q + 1'b1;
      if (sf_wrap) begin
        if (state_q == S_WRITE) begin
          if (NF == 1) begin
            nf_d = '0;
          end else begin
            state_d = S_READ;
            nf_d    = AW_NF'(1);
          end
        end else if (nf_q == NF_LAST) begin
          state_d = S_WRITE;
          nf_d    = '0;
        end else begin
          nf_d = nf_q + 1'b1;
        end
      end
    end

    // Tag pipe mirrors the datapath latency and freezes with it.
    tag_d = tag_q;
    if (pe_en) begin
      tag_d[0] = acc_last;
      for (int i = 1; i < PE_LAT; i++) begin
        tag_d[i] = tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WRITE;
      sf_q    <= '0;
      nf_q    <= '0;
      waddr_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      sf_q    <= sf_d;
      nf_q    <= nf_d;
      waddr_q <= waddr_d;
      tag_q   <= tag_d;
    end
  end

endmodule
